small_svf_mc: RTL and testbench
===============================

// Module: small_svf_mc
// PURPOSE
// - Multi-channel, time-multiplexed 2-pole shift-and-add state-variable filter; no multipliers.
// - Per-sample selectable low-pass / band-pass / high-pass output; shifts K0/K1 set at runtime.
// - Sits in small-filter chains after decimators; one shared datapath serves CHANNELS streams.
// - Per-channel state held in register arrays. Coefficients: K0=2^-k0 ~ 2*pi*Fc/Q, K1=2^-k1 ~ 2*pi*Fc*Q.
// PARAMETERS
// - WIDTH    16  data width, signed two's complement
// - CHANNELS 4   number of independent channels (>=1, need not be a power of 2)
// - K_MAX    12  largest shift supported; sets accumulator width AW = WIDTH+K_MAX
// - CW       2   channel index width, >= clog2(CHANNELS), min 1
// PORTS
// - clk        in   1      system clock
// - rst        in   1      reset, synchronous, active-high
// - in_valid   in   1      sample present
// - in_ready   out  1      block can accept; transfer when in_valid & in_ready
// - in_chan    in   CW     channel of sample
// - in_data    in   WIDTH  signed sample
// - in_mode    in   2      00 LP, 01 BP, 10 HP, 11 LP (alias)
// - k0_shift   in   4      K0 shift; values > K_MAX treated as K_MAX
// - k1_shift   in   4      K1 shift; values > K_MAX treated as K_MAX
// - out_valid  out  1      one-cycle pulse, result valid
// - out_chan   out  CW     channel of result
// - out_data   out  WIDTH  signed result
// - sat_clr    in   1      clear sticky saturation flags (feature-gated)
// - sat_flags  out  CHANNELS  sticky per-channel saturation (feature-gated)
// BEHAVIOUR
// - FSM: IDLE (in_ready=1) -> CALC on accept; CALC (in_ready=0) -> IDLE unconditionally next edge.
// - Throughput 1 sample / 2 clk. Accept at edge N; state write-back + output regs at edge N+1;
//   out_valid high for exactly the cycle after edge N+1. No output back-pressure.
// - in_chan, in_data, in_mode, k0_shift, k1_shift all captured at accept; stable for CALC.
// - Per channel c: acc0[c], acc1[c] signed AW bits. bp = acc0>>>k0, lp = acc1>>>k1 (arith shift,
//   truncated to WIDTH, using pre-update state).
// - acc0n = acc0 + x - bp - lp ; acc1n = acc1 + bp ; computed in AW+2 bits, saturated to AW
//   (max positive / min negative) before write-back.
// - Output: LP -> lp, BP -> bp, HP -> x - bp - lp computed in WIDTH+2 bits, saturated to WIDTH.
//   Output uses pre-update state (one-sample filter delay, as DSP model).
// - in_chan >= CHANNELS: sample accepted, FSM still spends CALC, no state change, no out_valid.
// - Reset: all acc0/acc1 = 0, FSM = IDLE, in_ready=1 in cycle after reset edge, out_valid=0,
//   out_chan=0, out_data=0, sat_flags=0. rst during CALC aborts: no write-back, no out_valid.
// - k shift changes only affect samples accepted after the change; state is not rescaled.
// CONFIGURATION
// - Macro SMALL_SVF_SAT_FLAGS_EN defined: sat_flags[c] sets on any acc0/acc1/HP-output
//   saturation of channel c, sticky; sat_clr clears all flags at next edge; a set event in the
//   same cycle as sat_clr wins (flag stays 1).
// - Not defined: sat_flags tied to 0, sat_clr ignored; saturation arithmetic still active.
// TESTING
// - Handshake: in_valid held 1 -> in_ready 1,0,1,0...; out_valid 2 cycles after each accept, out_chan matches.
// - LP step: WIDTH=16, k0=k1=4, ch0 x=1000 LP -> out converges to 1000 +/-2 within 2000
//   samples, monotonic overshoot < 25%; ch1 fed 0 stays exactly 0 (channel isolation).
// - HP/BP on DC: ch2 x=1000, HP and BP outputs decay to |out|<=2 after 2000 samples.
// - Saturation: k0=k1=0, alternating x=+32767/-32768 on ch3 -> out_data within +/-32767/-32768,
//   no wrap; with macro sat_flags=4'b1000 sticky until sat_clr pulse -> 0.
// - Reset mid-op: assert rst in CALC -> no out_valid, next LP output on that channel = 0.
// - Bad channel: CHANNELS=3, in_chan=3 -> accepted, no out_valid, all channel states unchanged.

Source files
------------

// File: rtl/small_svf_mc.sv
// small_svf_mc: multi-channel, time-multiplexed 2-pole shift-and-add state-variable filter.
// One shared datapath serves CHANNELS streams; per-channel integrator state is kept in
// register arrays. Each accepted sample takes two clocks (IDLE -> CALC -> IDLE).
// Optional feature: define SMALL_SVF_SAT_FLAGS_EN for sticky per-channel saturation flags.
// Without it, sat_flags is tied to 0 and sat_clr is ignored.
module small_svf_mc #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned K_MAX    = 12,
  parameter int unsigned CW       = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW-1:0]       in_chan,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [1:0]          in_mode,
  input  logic [3:0]          k0_shift,
  input  logic [3:0]          k1_shift,
  output logic                out_valid,
  output logic [CW-1:0]       out_chan,
  output logic [WIDTH-1:0]    out_data,
  input  logic                sat_clr,
  output logic [CHANNELS-1:0] sat_flags
);

  localparam int unsigned AW = WIDTH + K_MAX;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StCalc = 1'b1;

  localparam logic [1:0] ModeBp = 2'b01;
  localparam logic [1:0] ModeHp = 2'b10;

  logic [0:0]              state_q;
  logic [CW-1:0]           chan_q;
  logic signed [WIDTH-1:0] x_q;
  logic [1:0]              mode_q;
  logic [3:0]              k0_q, k1_q;
  logic signed [AW-1:0]    acc0_q [CHANNELS];
  logic signed [AW-1:0]    acc1_q [CHANNELS];

  logic                    out_valid_q;
  logic [CW-1:0]           out_chan_q;
  logic [WIDTH-1:0]        out_data_q;

  logic                    accept;
  logic [3:0]              k0_eff, k1_eff;
  logic                    chan_ok;
  logic signed [AW-1:0]    acc0_cur, acc1_cur;
  logic signed [WIDTH-1:0] bp, lp;
  logic signed [AW+1:0]    acc0_sum, acc1_sum;
  logic signed [WIDTH+1:0] hp_sum;
  logic                    acc0_ovf, acc1_ovf, hp_ovf;
  logic signed [AW-1:0]    acc0_n, acc1_n;
  logic signed [WIDTH-1:0] hp;
  logic [WIDTH-1:0]        y;
  logic                    sat_evt;
  logic                    write_back;

  assign in_ready   = (state_q == StIdle);
  assign accept     = in_valid & in_ready;
  assign out_valid  = out_valid_q;
  assign out_chan   = out_chan_q;
  assign out_data   = out_data_q;

  // Clamp requested shifts to the range the accumulator width supports.
  always_comb begin
    k0_eff = (32'(k0_shift) > K_MAX) ? 4'(K_MAX) : k0_shift;
    k1_eff = (32'(k1_shift) > K_MAX) ? 4'(K_MAX) : k1_shift;
  end

  // Select the pre-update state of the captured channel; out-of-range channels read zero.
  always_comb begin
    acc0_cur = '0;
    acc1_cur = '0;
    chan_ok  = 1'b0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (chan_q == CW'(c)) begin
        acc0_cur = acc0_q[c];
        acc1_cur = acc1_q[c];
        chan_ok  = 1'b1;
      end
    end
  end

  // Shift-and-add datapath with saturation of accumulators and the HP output.
  always_comb begin
    bp       = WIDTH'(acc0_cur >>> k0_q);
    lp       = WIDTH'(acc1_cur >>> k1_q);
    acc0_sum = (AW+2)'(acc0_cur) + (AW+2)'(x_q) - (AW+2)'(bp) - (AW+2)'(lp);
    acc1_sum = (AW+2)'(acc1_cur) + (AW+2)'(bp);
    hp_sum   = (WIDTH+2)'(x_q) - (WIDTH+2)'(bp) - (WIDTH+2)'(lp);

    // Result fits only if the top three bits all agree.
    acc0_ovf = (acc0_sum[AW+1:AW-1] != {3{acc0_sum[AW+1]}});
    acc1_ovf = (acc1_sum[AW+1:AW-1] != {3{acc1_sum[AW+1]}});
    hp_ovf   = (hp_sum[WIDTH+1:WIDTH-1] != {3{hp_sum[WIDTH+1]}});

    if (acc0_ovf) begin
      acc0_n = acc0_sum[AW+1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      acc0_n = acc0_sum[AW-1:0];
    end
    if (acc1_ovf) begin
      acc1_n = acc1_sum[AW+1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      acc1_n = acc1_sum[AW-1:0];
    end
    if (hp_ovf) begin
      hp = hp_sum[WIDTH+1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      hp = hp_sum[WIDTH-1:0];
    end

    case (mode_q)
      ModeBp:  y = bp;
      ModeHp:  y = hp;
      default: y = lp;
    endcase

    // HP saturation only counts when it actually reaches the output.
    sat_evt    = acc0_ovf | acc1_ovf | (hp_ovf && (mode_q == ModeHp));
    write_back = (state_q == StCalc) && chan_ok;
  end

  // FSM, sample capture, per-channel state write-back and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      chan_q      <= '0;
      x_q         <= '0;
      mode_q      <= '0;
      k0_q        <= '0;
      k1_q        <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        acc0_q[c] <= '0;
        acc1_q[c] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StCalc;
            chan_q  <= in_chan;
            x_q     <= in_data;
            mode_q  <= in_mode;
            k0_q    <= k0_eff;
            k1_q    <= k1_eff;
          end
        end
        default: begin
          state_q <= StIdle;
          if (write_back) begin
            out_valid_q <= 1'b1;
            out_chan_q  <= chan_q;
            out_data_q  <= y;
          end
          for (int c = 0; c < int'(CHANNELS); c++) begin
            if (write_back && (chan_q == CW'(c))) begin
              acc0_q[c] <= acc0_n;
              acc1_q[c] <= acc1_n;
            end
          end
        end
      endcase
    end
  end

`ifdef SMALL_SVF_SAT_FLAGS_EN
  logic [CHANNELS-1:0] sat_q;

  // Sticky flags: a set event in the same cycle as sat_clr keeps the flag high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= '0;
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        if (write_back && sat_evt && (chan_q == CW'(c))) begin
          sat_q[c] <= 1'b1;
        end else if (sat_clr) begin
          sat_q[c] <= 1'b0;
        end
      end
    end
  end

  assign sat_flags = sat_q;
`else
  logic sat_unused;

  assign sat_unused = sat_clr ^ sat_evt;
  assign sat_flags  = '0;
`endif

endmodule

// File: tb/tb_small_svf_mc.sv
// Directed self-checking bench for small_svf_mc. A second instance with CHANNELS=3 sees the
// same stimulus, so channel-3 samples exercise the out-of-range channel path there.
module tb_small_svf_mc;

  logic        clk = 1'b0;
  logic        rst, in_valid, sat_clr;
  logic [1:0]  in_chan, in_mode;
  logic [15:0] in_data;
  logic [3:0]  k0_shift, k1_shift;

  logic        in_ready, out_valid;
  logic [1:0]  out_chan;
  logic [15:0] out_data;
  logic [3:0]  sat_flags;

  logic        in_ready3, out_valid3;
  logic [1:0]  out_chan3;
  logic [15:0] out_data3;
  logic [2:0]  sat_flags3;

  int checks = 0;
  int errors = 0;

`ifdef SMALL_SVF_SAT_FLAGS_EN
  localparam logic [3:0] ExpFlag = 4'b1000;
`else
  localparam logic [3:0] ExpFlag = 4'b0000;
`endif

  localparam logic [1:0] Lp = 2'b00;
  localparam logic [1:0] Bp = 2'b01;
  localparam logic [1:0] Hp = 2'b10;

  always #5 clk = ~clk;

  small_svf_mc #(.WIDTH(16), .CHANNELS(4), .K_MAX(12), .CW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan),
    .in_data(in_data), .in_mode(in_mode), .k0_shift(k0_shift), .k1_shift(k1_shift),
    .out_valid(out_valid), .out_chan(out_chan), .out_data(out_data), .sat_clr(sat_clr),
    .sat_flags(sat_flags)
  );

  small_svf_mc #(.WIDTH(16), .CHANNELS(3), .K_MAX(12), .CW(2)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_chan(in_chan),
    .in_data(in_data), .in_mode(in_mode), .k0_shift(k0_shift), .k1_shift(k1_shift),
    .out_valid(out_valid3), .out_chan(out_chan3), .out_data(out_data3), .sat_clr(sat_clr),
    .sat_flags(sat_flags3)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Results of the most recent send.
  logic       r_v1, r_v2, r_v13, r_v23;
  logic [1:0] r_ch;
  logic [3:0] r_flags;
  int         r_y, r_y3;

  // One transfer: accept, then sample the CALC cycle and the result cycle.
  task automatic send(input logic [1:0] ch, input int x, input logic [1:0] md,
                      input logic [3:0] k0, input logic [3:0] k1);
    int n;
    @(negedge clk);
    in_chan  = ch;
    in_data  = 16'(x);
    in_mode  = md;
    k0_shift = k0;
    k1_shift = k1;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    r_v1  = out_valid;
    r_v13 = out_valid3;
    @(negedge clk);
    r_v2    = out_valid;
    r_v23   = out_valid3;
    r_ch    = out_chan;
    r_y     = int'($signed(out_data));
    r_y3    = int'($signed(out_data3));
    r_flags = sat_flags;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic exp_rdy [6];
    logic exp_ov  [6];
    int   ymax, nval, bad3;

    exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_ov  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; sat_clr = 1'b0; in_chan = '0; in_data = '0;
    in_mode = '0; k0_shift = 4'd4; k1_shift = 4'd4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_chan", out_chan, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sat_flags", sat_flags, 0);
    rst = 1'b0;

    // Handshake with in_valid held high on channel 1 (zero input).
    @(negedge clk);
    in_chan = 2'd1; in_data = '0; in_mode = Lp; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("hs_ready_%0d", i), in_ready, exp_rdy[i]);
      check($sformatf("hs_valid_%0d", i), out_valid, exp_ov[i]);
      if (i == 2) begin
        check("hs_chan", out_chan, 1);
        check("hs_data", out_data, 0);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("hs_valid_last", out_valid, 1);

    // LP step on channel 0, first samples hand-computed with k0=k1=4.
    send(2'd0, 1000, Lp, 4'd4, 4'd4);
    check("lat_calc_cycle", r_v1, 0);
    check("lat_result_cycle", r_v2, 1);
    check("step_chan", r_ch, 0);
    check("step_s1_lp", r_y, 0);
    send(2'd0, 1000, Bp, 4'd4, 4'd4);
    check("step_s2_bp", r_y, 62);
    send(2'd0, 1000, Hp, 4'd4, 4'd4);
    check("step_s3_hp", r_y, 876);
    send(2'd0, 1000, Lp, 4'd4, 4'd4);
    check("step_s4_lp", r_y, 11);
    ymax = r_y;
    nval = 4;
    for (int i = 4; i < 2000; i++) begin
      send(2'd0, 1000, Lp, 4'd4, 4'd4);
      if (r_v2) nval++;
      if (r_y > ymax) ymax = r_y;
    end
    check("step_valid_count", nval, 2000);
    check("step_overshoot_lt25", (ymax > 1000 && ymax < 1250), 1);
    check("step_final_pm2", (r_y >= 998 && r_y <= 1002), 1);

    send(2'd1, 0, Lp, 4'd4, 4'd4);
    check("iso_ch1_zero", r_y, 0);

    // DC into HP/BP on channel 2 decays to zero.
    for (int i = 0; i < 2000; i++) send(2'd2, 1000, Hp, 4'd4, 4'd4);
    check("dc_hp_pm2", (r_y >= -2 && r_y <= 2), 1);
    send(2'd2, 1000, Bp, 4'd4, 4'd4);
    check("dc_bp_pm2", (r_y >= -2 && r_y <= 2), 1);

    // Saturation on channel 3, k0=k1=0.
    bad3 = 0;
    send(2'd3, 32767, Hp, 4'd0, 4'd0);
    bad3 += int'(r_v13) + int'(r_v23);
    check("sat_s1_hp", r_y, 32767);
    check("sat_s1_flags", r_flags, 0);
    send(2'd3, -32768, Hp, 4'd0, 4'd0);
    bad3 += int'(r_v13) + int'(r_v23);
    check("sat_s2_hp_clamp", r_y, -32768);
    check("sat_s2_flags", r_flags, ExpFlag);
    send(2'd3, 32767, Lp, 4'd0, 4'd0);
    bad3 += int'(r_v13) + int'(r_v23);
    check("sat_s3_lp", r_y, 32767);
    check("sat_s3_chan", r_ch, 3);
    check("bad_chan_no_valid", bad3, 0);
    check("bad_chan_no_flags", sat_flags3, 0);

    // Out-of-range samples left the CHANNELS=3 instance's state alone.
    send(2'd0, 1000, Lp, 4'd4, 4'd4);
    check("post_ch0_pm2", (r_y >= 998 && r_y <= 1002), 1);
    check("bad_ch0_valid", r_v23, 1);
    check("bad_ch0_pm2", (r_y3 >= 998 && r_y3 <= 1002), 1);
    send(2'd2, 1000, Bp, 4'd4, 4'd4);
    check("bad_ch2_pm2", (r_y3 >= -2 && r_y3 <= 2), 1);

    // Sticky flags, then clear.
    repeat (2) @(negedge clk);
    check("sat_sticky", sat_flags, ExpFlag);
    sat_clr = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
    @(negedge clk);
    check("sat_cleared", sat_flags, 0);

    // Reset asserted during CALC aborts the sample and clears state.
    @(negedge clk);
    in_chan = 2'd0; in_data = 16'd1000; in_mode = Lp; k0_shift = 4'd4; k1_shift = 4'd4;
    in_valid = 1'b1;
    check("midrst_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_no_valid_a", out_valid, 0);
    @(negedge clk);
    check("midrst_no_valid_b", out_valid, 0);
    send(2'd0, 1000, Lp, 4'd4, 4'd4);
    check("midrst_lp_s1", r_y, 0);
    check("midrst_valid", r_v2, 1);
    send(2'd0, 1000, Bp, 4'd4, 4'd4);
    check("midrst_bp_s2", r_y, 62);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
